// File: rtl/lcd_ctrl.sv
// 8x8 grayscale image controller: loads the image from IROM, edits a 2x2 window on host commands, dumps to IRB.
// Optional build macro LCD_CTRL_ROUND_AVG_EN selects round-to-nearest averaging instead of truncation.
module lcd_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] cmd,
    input  logic       cmd_valid,
    input  logic [7:0] IROM_Q,
    output logic       IROM_EN,
    output logic [5:0] IROM_A,
    output logic       IRB_RW,
    output logic [5:0] IRB_A,
    output logic [7:0] IRB_D,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE, S_DONE} state_t;

`ifdef LCD_CTRL_ROUND_AVG_EN
    localparam logic [9:0] AVG_RND = 10'd2;
`else
    localparam logic [9:0] AVG_RND = 10'd0;
`endif

    state_t      state_q, state_d;
    logic [6:0]  req_cnt_q, req_cnt_d;
    logic        rom_en_q, rom_en_d;
    logic [5:0]  rom_a_q, rom_a_d;
    logic        rd_vld_q, rd_vld_d;
    logic [5:0]  rd_a_q, rd_a_d;
    logic [2:0]  cmd_q, cmd_d;
    logic [2:0]  x_q, x_d, y_q, y_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        irb_rw_q, irb_rw_d;
    logic [5:0]  irb_a_q, irb_a_d;
    logic [7:0]  irb_d_q, irb_d_d;

    logic [63:0][7:0] pix_flat;
    logic [2:0]  xm1, ym1;
    logic [5:0]  wa [4];
    logic [7:0]  wv [4];
    logic [7:0]  wn [4];
    logic [9:0]  sum;
    logic [7:0]  avg;
    logic        exec_we;
    logic [5:0]  irb_nxt;

    // Window order: 0=top-left, 1=top-right, 2=bottom-left, 3=bottom-right.
    assign xm1   = x_q - 3'd1;
    assign ym1   = y_q - 3'd1;
    assign wa[0] = {ym1, xm1};
    assign wa[1] = {ym1, x_q};
    assign wa[2] = {y_q, xm1};
    assign wa[3] = {y_q, x_q};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wv
            assign wv[gi] = pix_flat[wa[gi]];
        end
    endgenerate

    assign sum     = {2'b00, wv[0]} + {2'b00, wv[1]} + {2'b00, wv[2]} + {2'b00, wv[3]};
    assign avg     = 8'((sum + AVG_RND) >> 2);
    assign exec_we = (state_q == S_EXEC) && (cmd_q >= 3'd5);
    assign irb_nxt = irb_a_q + 6'd1;

    always_comb begin
        for (int k = 0; k < 4; k++) wn[k] = wv[k];
        case (cmd_q)
            3'd5: for (int k = 0; k < 4; k++) wn[k] = avg;
            3'd6: begin wn[0] = wv[2]; wn[1] = wv[3]; wn[2] = wv[0]; wn[3] = wv[1]; end
            3'd7: begin wn[0] = wv[1]; wn[1] = wv[0]; wn[2] = wv[3]; wn[3] = wv[2]; end
            default: ;
        endcase
    end

    // Pixel buffer: ROM capture during load, window rewrite during EXEC.
    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_pix
            logic [7:0] pix_q;
            always_ff @(posedge clk) begin
                if (rd_vld_q && rd_a_q == 6'(gi))
                    pix_q <= IROM_Q;
                else if (exec_we && wa[0] == 6'(gi))
                    pix_q <= wn[0];
                else if (exec_we && wa[1] == 6'(gi))
                    pix_q <= wn[1];
                else if (exec_we && wa[2] == 6'(gi))
                    pix_q <= wn[2];
                else if (exec_we && wa[3] == 6'(gi))
                    pix_q <= wn[3];
            end
            assign pix_flat[gi] = pix_q;
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        req_cnt_d = req_cnt_q;
        rom_en_d  = rom_en_q;
        rom_a_d   = rom_a_q;
        rd_vld_d  = ~rom_en_q;
        rd_a_d    = rom_a_q;
        cmd_d     = cmd_q;
        x_d       = x_q;
        y_d       = y_q;
        busy_d    = busy_q;
        done_d    = done_q;
        irb_rw_d  = irb_rw_q;
        irb_a_d   = irb_a_q;
        irb_d_d   = irb_d_q;
        case (state_q)
            S_LOAD: begin
                if (!req_cnt_q[6]) begin
                    rom_en_d  = 1'b0;
                    rom_a_d   = req_cnt_q[5:0];
                    req_cnt_d = req_cnt_q + 7'd1;
                end else begin
                    rom_en_d  = 1'b1;
                end
                if (rd_vld_q && rd_a_q == 6'd63) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_d  = cmd;
                    busy_d = 1'b1;
                    if (cmd == 3'd0) begin
                        state_d  = S_WRITE;
                        irb_rw_d = 1'b0;
                        irb_a_d  = 6'd0;
                        irb_d_d  = pix_flat[0];
                    end else begin
                        state_d  = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                case (cmd_q)
                    3'd1: if (y_q != 3'd1) y_d = y_q - 3'd1;
                    3'd2: if (y_q != 3'd7) y_d = y_q + 3'd1;
                    3'd3: if (x_q != 3'd1) x_d = x_q - 3'd1;
                    3'd4: if (x_q != 3'd7) x_d = x_q + 3'd1;
                    default: ;
                endcase
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            S_WRITE: begin
                if (irb_a_q == 6'd63) begin
                    state_d  = S_DONE;
                    irb_rw_d = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    irb_a_d  = irb_nxt;
                    irb_d_d  = pix_flat[irb_nxt];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_LOAD;
            req_cnt_q <= 7'd0;
            rom_en_q  <= 1'b1;
            rom_a_q   <= 6'd0;
            rd_vld_q  <= 1'b0;
            rd_a_q    <= 6'd0;
            cmd_q     <= 3'd0;
            x_q       <= 3'd4;
            y_q       <= 3'd4;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            irb_rw_q  <= 1'b1;
            irb_a_q   <= 6'd0;
            irb_d_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
            rom_en_q  <= rom_en_d;
            rom_a_q   <= rom_a_d;
            rd_vld_q  <= rd_vld_d;
            rd_a_q    <= rd_a_d;
            cmd_q     <= cmd_d;
            x_q       <= x_d;
            y_q       <= y_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            irb_rw_q  <= irb_rw_d;
            irb_a_q   <= irb_a_d;
            irb_d_q   <= irb_d_d;
        end
    end

    assign IROM_EN = rom_en_q;
    assign IROM_A  = rom_a_q;
    assign IRB_RW  = irb_rw_q;
    assign IRB_A   = irb_a_q;
    assign IRB_D   = irb_d_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_lcd_ctrl.sv
// Scoreboard bench for lcd_ctrl: expected IRB writes are queued at command issue, a negedge monitor pops and compares.
module tb_lcd_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] cmd = 3'd0;
    logic       cmd_valid = 1'b0;
    logic [7:0] IROM_Q = 8'd0;
    logic       IROM_EN;
    logic [5:0] IROM_A;
    logic       IRB_RW;
    logic [5:0] IRB_A;
    logic [7:0] IRB_D;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    logic [13:0] exp_q[$];
    logic [13:0] mon_e;
    logic [7:0]  rom [64];
    logic [7:0]  exp_img [64];

    lcd_ctrl dut (
        .clk(clk), .reset(reset), .cmd(cmd), .cmd_valid(cmd_valid), .IROM_Q(IROM_Q),
        .IROM_EN(IROM_EN), .IROM_A(IROM_A), .IRB_RW(IRB_RW), .IRB_A(IRB_A),
        .IRB_D(IRB_D), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous image ROM.
    always @(posedge clk) if (!IROM_EN) IROM_Q <= rom[IROM_A];

    // Monitor: every IRB write cycle must match the head of the scoreboard queue.
    always @(negedge clk) begin
        if (!reset && !IRB_RW) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL irb_unexpected got addr=%0d data=%0d required no write", IRB_A, IRB_D);
            end else begin
                mon_e = exp_q.pop_front();
                if ({IRB_A, IRB_D} !== mon_e) begin
                    errors++;
                    $display("FAIL irb_write got addr=%0d data=%0d required addr=%0d data=%0d",
                             IRB_A, IRB_D, mon_e[13:8], mon_e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    task automatic do_reset();
        int n;
        @(negedge clk);
        reset = 1'b1; cmd_valid = 1'b0; cmd = 3'd0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_irom_en", IROM_EN, 1);
        check("rst_irom_a", IROM_A, 0);
        check("rst_irb_rw", IRB_RW, 1);
        check("rst_irb_a", IRB_A, 0);
        check("rst_irb_d", IRB_D, 0);
        reset = 1'b0;
        cmd = 3'd4; cmd_valid = 1'b1;   // must be ignored throughout LOAD
        @(negedge clk);
        check("load_first_en", IROM_EN, 0);
        check("load_first_a", IROM_A, 0);
        @(negedge clk);
        check("load_second_a", IROM_A, 1);
        n = 2;
        while (busy && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (n < 65 || n > 66) begin
            errors++;
            $display("FAIL load_busy_fall got %0d cycles required 65..66", n);
        end
        check("load_rom_released", IROM_EN, 1);
        for (int i = 0; i < 64; i++) exp_img[i] = rom[i];
        $display("reset done, busy fell after %0d cycles", n);
    endtask

    // Host keeps cmd_valid high; the new code is presented at the negedge after the previous acceptance.
    task automatic issue(input logic [2:0] c, input bit chk_pulse);
        int n;
        cmd = c; cmd_valid = 1'b1;
        n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        check("busy_low_wait", busy, 0);
        if (chk_pulse) check("busy_pulse_len", n, 1);
        @(negedge clk);
        check("cmd_accept", busy, 1);
        $display("cmd %0d issued, busy high cycles before it %0d", c, n);
    endtask

    task automatic write_and_finish(input bit chk_pulse);
        int n;
        for (int i = 0; i < 64; i++) exp_q.push_back({6'(i), exp_img[i]});
        issue(3'd0, chk_pulse);
        cmd = 3'd2;
        n = 0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        check("done_rise", done, 1);
        check("done_latency", n, 64);
        check("writes_left_at_done", exp_q.size(), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("done_hold", {busy, done, IRB_RW}, 3'b111);
        end
        cmd_valid = 1'b0;
        $display("write finished, done after %0d cycles", n);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 8'((i * 37 + 5) % 256);
        rom[3]  = 8'd10;  rom[4]  = 8'd20;  rom[11] = 8'd30;  rom[12] = 8'd41;
        rom[54] = 8'd1;   rom[55] = 8'd2;   rom[62] = 8'd3;   rom[63] = 8'd4;
        rom[27] = 8'hA1;  rom[28] = 8'hB2;  rom[35] = 8'hC3;  rom[36] = 8'hD4;

        // Plain copy of the ROM.
        do_reset();
        write_and_finish(1'b0);

        // Y clamps at 1, average of 10,20,30,41 = 25 (also 25 when rounding).
        do_reset();
        issue(3'd1, 1'b0);
        for (int i = 0; i < 4; i++) issue(3'd1, 1'b1);
        issue(3'd5, 1'b1);
        exp_img[3] = 8'd25; exp_img[4] = 8'd25; exp_img[11] = 8'd25; exp_img[12] = 8'd25;
        write_and_finish(1'b1);

        // Corner (7,7), Mirror X on 1,2,3,4.
        do_reset();
        issue(3'd4, 1'b0);
        for (int i = 0; i < 3; i++) issue(3'd4, 1'b1);
        for (int i = 0; i < 4; i++) issue(3'd2, 1'b1);
        issue(3'd6, 1'b1);
        exp_img[54] = 8'd3; exp_img[55] = 8'd4; exp_img[62] = 8'd1; exp_img[63] = 8'd2;
        write_and_finish(1'b1);

        // Mirror Y at reset point.
        do_reset();
        issue(3'd7, 1'b0);
        exp_img[27] = 8'hB2; exp_img[28] = 8'hA1; exp_img[35] = 8'hD4; exp_img[36] = 8'hC3;
        write_and_finish(1'b1);

        // Reset mid-write, then Mirror Y again proves point is back at (4,4).
        do_reset();
        for (int i = 0; i < 64; i++) exp_q.push_back({6'(i), exp_img[i]});
        issue(3'd0, 1'b0);
        cmd = 3'd2;
        repeat (20) @(negedge clk);
        $display("reset asserted mid-write");
        do_reset();
        issue(3'd7, 1'b0);
        exp_img[27] = 8'hB2; exp_img[28] = 8'hA1; exp_img[35] = 8'hD4; exp_img[36] = 8'hC3;
        write_and_finish(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end
endmodule
